mem_stage_pipe: RTL and testbench

- Parametrised memory stage: EX/MEM pipeline register, byte-enabled data RAM and MEM/WB pipeline register in one block.
- Adds byte, halfword and word access with sign/zero extension.
- Adds stall/flush control, valid tracking and MEM-stage forwarding taps.
- Sits between the ALU stage and register-file writeback of the core.

---
 rtl/mem_stage_pipe_pkg.sv | 74 +++++++
 rtl/mem_stage_pipe_data_ram_be.sv | 38 +++
 rtl/mem_stage_pipe.sv | 142 ++++++++++++++
 tb/tb_mem_stage_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pipe_pkg.sv
// Shared size encoding and byte-lane helpers for the memory stage.
// The lane helpers work on a 32-bit word of four byte lanes.
package mem_stage_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // Encoding 2'b11 has no enum member of its own and behaves as a word.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] store_align(input size_e sz, input logic [WORD_W-1:0] data);
        case (sz)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] store_merge(input logic [WORD_W-1:0] old_w,
                                                      input logic [WORD_W-1:0] new_w,
                                                      input logic [LANES-1:0]  mask);
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

    // Only the offset bits that matter for the size are used, so low bits are aligned away.
    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input size_e             sz,
                                                      input logic              sgn,
                                                      input logic [1:0]        off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: return sgn ? {{24{b[7]}}, b} : {24'b0, b};
            SZ_HALF: return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_pipe_data_ram_be.sv
// Single-port data RAM with byte enables, synchronous read and write-first read data.
module data_ram_be
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [NB-1:0]     i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_merged;

    assign w_merged = store_merge(r_mem[i_addr], i_wdata, i_be);

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) r_mem[i_addr] <= w_merged;
    end

    // The read register belongs to the MEM/WB boundary, so it is cleared on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_en) begin
            o_rdata <= i_we ? w_merged : r_mem[i_addr];
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory stage: EX/MEM register, byte-enabled data RAM and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module mem_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int REG_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_ex_i,
    input  logic [DATA_W-1:0] RD2_ex_i,
    input  logic [DATA_W-1:0] AluResult_ex_i,
    input  logic [REG_W-1:0]  A3_ex_i,
    input  logic              RF_WE_ex_i,
    input  logic              MemWE_ex_i,
    input  logic              WBSelect_ex_i,
    input  logic [1:0]        size_ex_i,
    input  logic              signed_ex_i,
    output logic [REG_W-1:0]  A3_mem_o,
    output logic              RF_WE_mem_o,
    output logic [DATA_W-1:0] AluResult_mem_o,
    output logic              valid_wb_o,
    output logic              RF_WE_wb_o,
    output logic              WBSelect_wb_o,
    output logic [DATA_W-1:0] AluResult_wb_o,
    output logic [DATA_W-1:0] ReadData_wb_o,
    output logic [REG_W-1:0]  A3_wb_o,
    output logic [DATA_W-1:0] WBData_wb_o,
    output logic              misalign_wb_o
);

    import mem_stage_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    logic              r_valid_mem, r_rfwe_mem, r_memwe_mem, r_wbsel_mem, r_signed_mem;
    logic [DATA_W-1:0] r_alu_mem, r_rd2_mem;
    logic [REG_W-1:0]  r_a3_mem;
    size_e             r_size_mem;

    logic              r_valid_wb, r_rfwe_wb, r_wbsel_wb, r_signed_wb, r_mis_wb;
    logic [DATA_W-1:0] r_alu_wb;
    logic [REG_W-1:0]  r_a3_wb;
    size_e             r_size_wb;

    logic [1:0]        w_off;
    logic              w_mis, w_ram_we;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata, w_ram_rdata, w_read_ext;

    // A flushed op keeps its payload but loses its valid bit and every enable.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid_mem  <= 1'b0;
            r_rfwe_mem   <= 1'b0;
            r_memwe_mem  <= 1'b0;
            r_wbsel_mem  <= 1'b0;
            r_signed_mem <= 1'b0;
            r_alu_mem    <= '0;
            r_rd2_mem    <= '0;
            r_a3_mem     <= '0;
            r_size_mem   <= SZ_BYTE;
        end else if (!stall_i) begin
            r_valid_mem  <= valid_ex_i & ~flush_i;
            r_rfwe_mem   <= RF_WE_ex_i & ~flush_i;
            r_memwe_mem  <= MemWE_ex_i & ~flush_i;
            r_wbsel_mem  <= WBSelect_ex_i;
            r_signed_mem <= signed_ex_i;
            r_alu_mem    <= AluResult_ex_i;
            r_rd2_mem    <= RD2_ex_i;
            r_a3_mem     <= A3_ex_i;
            r_size_mem   <= decode_size(size_ex_i);
        end
    end

    always_comb begin
        w_off = r_alu_mem[1:0];
`ifdef MISALIGN_TRAP_EN
        w_mis = r_valid_mem & (r_memwe_mem | r_wbsel_mem) & misaligned(r_size_mem, w_off);
`else
        w_mis = 1'b0;
`endif
        w_ram_we = r_valid_mem & r_memwe_mem & ~w_mis;
        w_be     = lane_mask(r_size_mem, w_off);
        w_wdata  = store_align(r_size_mem, r_rd2_mem);
    end

    // The RAM port is the MEM->WB edge: a stall freezes both the write and the read data.
    data_ram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_en    (~stall_i),
        .i_we    (w_ram_we),
        .i_be    (w_be),
        .i_addr  (r_alu_mem[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid_wb  <= 1'b0;
            r_rfwe_wb   <= 1'b0;
            r_wbsel_wb  <= 1'b0;
            r_signed_wb <= 1'b0;
            r_mis_wb    <= 1'b0;
            r_alu_wb    <= '0;
            r_a3_wb     <= '0;
            r_size_wb   <= SZ_BYTE;
        end else if (!stall_i) begin
            r_valid_wb  <= r_valid_mem;
            r_rfwe_wb   <= r_valid_mem & r_rfwe_mem & ~w_mis;
            r_wbsel_wb  <= r_wbsel_mem;
            r_signed_wb <= r_signed_mem;
            r_mis_wb    <= w_mis;
            r_alu_wb    <= r_alu_mem;
            r_a3_wb     <= r_a3_mem;
            r_size_wb   <= r_size_mem;
        end
    end

    assign w_read_ext = load_extend(w_ram_rdata, r_size_wb, r_signed_wb, r_alu_wb[1:0]);

    assign A3_mem_o        = r_a3_mem;
    assign RF_WE_mem_o     = r_valid_mem & r_rfwe_mem;
    assign AluResult_mem_o = r_alu_mem;
    assign valid_wb_o      = r_valid_wb;
    assign RF_WE_wb_o      = r_valid_wb & r_rfwe_wb;
    assign WBSelect_wb_o   = r_wbsel_wb;
    assign AluResult_wb_o  = r_alu_wb;
    assign ReadData_wb_o   = w_read_ext;
    assign A3_wb_o         = r_a3_wb;
    assign WBData_wb_o     = r_wbsel_wb ? w_read_ext : r_alu_wb;
    assign misalign_wb_o   = r_mis_wb;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with a byte-level memory model and per-cycle compare.
// Build with MISALIGN_TRAP_EN defined to match a trapping DUT.
module tb_mem_stage_pipe;

    localparam int DEPTH = 1024;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
`ifdef MISALIGN_TRAP_EN
    localparam bit          TRAP_ON = 1'b1;
    localparam logic [31:0] EXP40   = 32'hDEADBEEF;
`else
    localparam bit          TRAP_ON = 1'b0;
    localparam logic [31:0] EXP40   = 32'h0BADF00D;
`endif

    typedef struct {
        bit          valid;
        bit          rfWe;
        bit          memWe;
        bit          wbSel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  a3;
        logic [1:0]  size;
        bit          sgn;
    } op_t;

    logic        CLK = 1'b0, RST = 1'b0;
    logic        stallIn = 1'b0, flushIn = 1'b0, validEx = 1'b0;
    logic [31:0] rd2Ex = '0, aluEx = '0;
    logic [3:0]  a3Ex = '0;
    logic        rfWeEx = 1'b0, memWeEx = 1'b0, wbSelEx = 1'b0, signedEx = 1'b0;
    logic [1:0]  sizeEx = '0;

    logic [3:0]  A3_mem_o, A3_wb_o;
    logic        RF_WE_mem_o, valid_wb_o, RF_WE_wb_o, WBSelect_wb_o, misalign_wb_o;
    logic [31:0] AluResult_mem_o, AluResult_wb_o, ReadData_wb_o, WBData_wb_o;

    int passCount  = 0;
    int checkCount = 0;
    bit checkOn    = 1'b0;

    op_t         memOp, wbOp, idle;
    bit          wbMis;
    bit          readKnown;
    logic [31:0] expRead;
    logic [31:0] modelMem [int];

    mem_stage_pipe #(.DATA_W(32), .DEPTH(DEPTH), .REG_W(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .stall_i         (stallIn),
        .flush_i         (flushIn),
        .valid_ex_i      (validEx),
        .RD2_ex_i        (rd2Ex),
        .AluResult_ex_i  (aluEx),
        .A3_ex_i         (a3Ex),
        .RF_WE_ex_i      (rfWeEx),
        .MemWE_ex_i      (memWeEx),
        .WBSelect_ex_i   (wbSelEx),
        .size_ex_i       (sizeEx),
        .signed_ex_i     (signedEx),
        .A3_mem_o        (A3_mem_o),
        .RF_WE_mem_o     (RF_WE_mem_o),
        .AluResult_mem_o (AluResult_mem_o),
        .valid_wb_o      (valid_wb_o),
        .RF_WE_wb_o      (RF_WE_wb_o),
        .WBSelect_wb_o   (WBSelect_wb_o),
        .AluResult_wb_o  (AluResult_wb_o),
        .ReadData_wb_o   (ReadData_wb_o),
        .A3_wb_o         (A3_wb_o),
        .WBData_wb_o     (WBData_wb_o),
        .misalign_wb_o   (misalign_wb_o)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit isMisaligned(input op_t op);
        return op.valid && (op.memWe || op.wbSel) && ((int'(op.addr[1:0]) % sizeBytes(op.size)) != 0);
    endfunction

    function automatic logic [31:0] loadValue(input logic [31:0] word, input op_t op);
        int     n, base;
        longint v;
        n    = sizeBytes(op.size);
        base = (int'(op.addr[1:0]) / n) * n;
        v    = (longint'(word) >> (8 * base)) & ((longint'(1) << (8 * n)) - 1);
        if (op.sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] storeValue(input logic [31:0] word, input op_t op);
        int          n, base;
        logic [31:0] w;
        n    = sizeBytes(op.size);
        base = (int'(op.addr[1:0]) / n) * n;
        w    = word;
        for (int k = 0; k < n; k++) w[8 * (base + k) +: 8] = op.data[8 * k +: 8];
        return w;
    endfunction

    function automatic op_t mkStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        op_t o;
        o = '{default: '0};
        o.valid = 1'b1; o.memWe = 1'b1; o.addr = addr; o.data = data; o.size = size;
        return o;
    endfunction

    function automatic op_t mkLoad(input logic [31:0] addr, input logic [1:0] size, input bit sgn, input logic [3:0] a3);
        op_t o;
        o = '{default: '0};
        o.valid = 1'b1; o.rfWe = 1'b1; o.wbSel = 1'b1; o.addr = addr; o.size = size; o.sgn = sgn; o.a3 = a3;
        return o;
    endfunction

    function automatic op_t mkAlu(input logic [31:0] value, input logic [3:0] a3);
        op_t o;
        o = '{default: '0};
        o.valid = 1'b1; o.rfWe = 1'b1; o.addr = value; o.a3 = a3; o.data = 32'hFFFF_0000;
        return o;
    endfunction

    task automatic modelReset();
        memOp     = '{default: '0};
        wbOp      = '{default: '0};
        wbMis     = 1'b0;
        expRead   = '0;
        readKnown = 1'b1;
    endtask

    // What one clock edge does to the two pipeline slots and the memory.
    task automatic modelEdge(input bit st, input bit fl, input op_t inOp);
        bit mis;
        int idx;
        if (st) return;
        mis       = TRAP_ON && isMisaligned(memOp);
        idx       = int'(memOp.addr[31:2]) % DEPTH;
        readKnown = 1'b0;
        if (memOp.valid && memOp.wbSel && !mis && modelMem.exists(idx)) begin
            expRead   = loadValue(modelMem[idx], memOp);
            readKnown = 1'b1;
        end
        if (memOp.valid && memOp.memWe && !mis) begin
            modelMem[idx] = storeValue(modelMem.exists(idx) ? modelMem[idx] : 32'h0, memOp);
        end
        wbOp  = memOp;
        wbMis = mis;
        memOp = inOp;
        if (fl) begin
            memOp.valid = 1'b0;
            memOp.rfWe  = 1'b0;
            memOp.memWe = 1'b0;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput();
        checkVal("valid_wb", 32'(valid_wb_o), 32'(wbOp.valid));
        checkVal("rf_we_wb", 32'(RF_WE_wb_o), 32'(wbOp.valid && wbOp.rfWe && !wbMis));
        checkVal("wbsel_wb", 32'(WBSelect_wb_o), 32'(wbOp.wbSel));
        checkVal("alu_wb", AluResult_wb_o, wbOp.addr);
        checkVal("a3_wb", 32'(A3_wb_o), 32'(wbOp.a3));
        checkVal("misalign_wb", 32'(misalign_wb_o), 32'(wbMis));
        checkVal("a3_mem", 32'(A3_mem_o), 32'(memOp.a3));
        checkVal("rf_we_mem", 32'(RF_WE_mem_o), 32'(memOp.valid && memOp.rfWe));
        checkVal("alu_mem", AluResult_mem_o, memOp.addr);
        if (readKnown) begin
            checkVal("read_wb", ReadData_wb_o, expRead);
            checkVal("wbdata_wb", WBData_wb_o, wbOp.wbSel ? expRead : wbOp.addr);
        end else if (!wbOp.wbSel) begin
            checkVal("wbdata_wb", WBData_wb_o, wbOp.addr);
        end
    endtask

    always begin
        @(posedge CLK);
        #1;
        if (checkOn) checkOutput();
    end

    task automatic applyStimulus(input op_t op, input bit st, input bit fl);
        validEx  = op.valid;
        rd2Ex    = op.data;
        aluEx    = op.addr;
        a3Ex     = op.a3;
        rfWeEx   = op.rfWe;
        memWeEx  = op.memWe;
        wbSelEx  = op.wbSel;
        sizeEx   = op.size;
        signedEx = op.sgn;
        stallIn  = st;
        flushIn  = fl;
        @(posedge CLK);
        modelEdge(st, fl, op);
        #2;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_valid_wb"}, 32'(valid_wb_o), 32'h0);
        checkVal({tag, "_rf_we_wb"}, 32'(RF_WE_wb_o), 32'h0);
        checkVal({tag, "_rf_we_mem"}, 32'(RF_WE_mem_o), 32'h0);
        checkVal({tag, "_alu_mem"}, AluResult_mem_o, 32'h0);
        checkVal({tag, "_alu_wb"}, AluResult_wb_o, 32'h0);
        checkVal({tag, "_read_wb"}, ReadData_wb_o, 32'h0);
        checkVal({tag, "_wbdata_wb"}, WBData_wb_o, 32'h0);
        checkVal({tag, "_misalign_wb"}, 32'(misalign_wb_o), 32'h0);
    endtask

    initial begin
        op_t tmp;
        idle = '{default: '0};
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checkResetOutputs("reset");
        @(negedge CLK);
        RST = 1'b1;
        checkOn = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(mkStore(32'(4 * i), 32'(4 * i), SW), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i < 4) ? mkLoad(32'(4 * i), SW, 1'b0, 4'(i + 1)) : idle, 1'b0, 1'b0);
            if (i >= 1) begin
                checkVal("word_load_data", ReadData_wb_o, 32'(4 * (i - 1)));
                checkVal("word_load_wbdata", WBData_wb_o, 32'(4 * (i - 1)));
            end
        end

        applyStimulus(mkStore(32'h20, 32'h11223344, SW), 1'b0, 1'b0);
        applyStimulus(mkStore(32'h21, 32'h123456AA, SB), 1'b0, 1'b0);
        applyStimulus(mkStore(32'h24, 32'h00000000, SW), 1'b0, 1'b0);
        applyStimulus(mkStore(32'h26, 32'h7777BEEF, SH), 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h20, SW, 1'b0, 4'd1), 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h21, SB, 1'b1, 4'd2), 1'b0, 1'b0);
        checkVal("word_after_byte", ReadData_wb_o, 32'h1122AA44);
        applyStimulus(mkLoad(32'h21, SB, 1'b0, 4'd3), 1'b0, 1'b0);
        checkVal("signed_byte", ReadData_wb_o, 32'hFFFFFFAA);
        applyStimulus(mkLoad(32'h20, SH, 1'b1, 4'd4), 1'b0, 1'b0);
        checkVal("unsigned_byte", ReadData_wb_o, 32'h000000AA);
        applyStimulus(mkLoad(32'h22, SH, 1'b0, 4'd5), 1'b0, 1'b0);
        checkVal("signed_half", ReadData_wb_o, 32'hFFFFAA44);
        applyStimulus(mkLoad(32'h24, SW, 1'b0, 4'd6), 1'b0, 1'b0);
        checkVal("unsigned_half", ReadData_wb_o, 32'h00001122);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("half_store", ReadData_wb_o, 32'hBEEF0000);

        applyStimulus(mkStore(32'h60, 32'h0, SW), 1'b0, 1'b0);
        applyStimulus(mkAlu(32'h1234, 4'd5), 1'b0, 1'b0);
        applyStimulus(mkStore(32'h60, 32'h55667788, SW), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(mkLoad(32'h20, SB, 1'b1, 4'd9), 1'b1, 1'b0);
        checkVal("stall_alu_wb", AluResult_wb_o, 32'h1234);
        checkVal("stall_wbdata", WBData_wb_o, 32'h1234);
        checkVal("stall_alu_mem", AluResult_mem_o, 32'h60);
        applyStimulus(idle, 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h60, SW, 1'b0, 4'd7), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("after_stall_store", ReadData_wb_o, 32'h55667788);
        for (int i = 0; i < 2; i++) applyStimulus(mkLoad(32'h20, SB, 1'b1, 4'd8), 1'b1, 1'b0);
        checkVal("stall_load_hold", ReadData_wb_o, 32'h55667788);
        applyStimulus(idle, 1'b0, 1'b0);

        applyStimulus(mkStore(32'h60, 32'h99, SW), 1'b0, 1'b1);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("flush_valid_wb", 32'(valid_wb_o), 32'h0);
        applyStimulus(mkLoad(32'h60, SW, 1'b0, 4'd7), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("flush_mem_kept", ReadData_wb_o, 32'h55667788);

        tmp = mkStore(32'h64, 32'hCAFEF00D, SW);
        tmp.rfWe = 1'b1;
        applyStimulus(tmp, 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h20, SW, 1'b0, 4'd3), 1'b1, 1'b1);
        checkVal("stall_flush_held", 32'(RF_WE_mem_o), 32'h1);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("stall_flush_valid_wb", 32'(valid_wb_o), 32'h1);
        applyStimulus(mkLoad(32'h64, SW, 1'b0, 4'd2), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("stall_flush_store", ReadData_wb_o, 32'hCAFEF00D);

        applyStimulus(mkStore(32'h40, 32'hDEADBEEF, SW), 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h40, SW, 1'b0, 4'd1), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("back_to_back", ReadData_wb_o, 32'hDEADBEEF);

        applyStimulus(mkStore(32'h1030, 32'h0A0B0C0D, SW), 1'b0, 1'b0);
        applyStimulus(mkLoad(32'h30, SW, 1'b0, 4'd1), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("address_wrap", ReadData_wb_o, 32'h0A0B0C0D);

        tmp = mkStore(32'h42, 32'h0BADF00D, SW);
        tmp.rfWe = 1'b1;
        applyStimulus(tmp, 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("misalign_flag", 32'(misalign_wb_o), 32'(TRAP_ON));
        checkVal("misalign_rf_we", 32'(RF_WE_wb_o), 32'(!TRAP_ON));
        checkVal("misalign_addr", AluResult_wb_o, 32'h42);
        applyStimulus(mkLoad(32'h40, SW, 1'b0, 4'd1), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("misalign_mem", ReadData_wb_o, EXP40);

        applyStimulus(mkStore(32'h40, 32'h77777777, SW), 1'b0, 1'b0);
        checkOn = 1'b0;
        RST = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        modelReset();
        checkOn = 1'b1;
        applyStimulus(mkLoad(32'h40, SW, 1'b0, 4'd1), 1'b0, 1'b0);
        applyStimulus(idle, 1'b0, 1'b0);
        checkVal("reset_discards_store", ReadData_wb_o, EXP40);
        applyStimulus(idle, 1'b0, 1'b0);

        checkOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
